// File: rtl/cluster_evt_pkg.sv
// Shared types and constants for the SoC-to-cluster event concentrator.
package cluster_evt_pkg;

  localparam int unsigned EVT_WIDTH_DEF = 8;

  typedef logic [EVT_WIDTH_DEF-1:0] evt_t;

  localparam logic EVT_ARB_RR   = 1'b0;
  localparam logic EVT_ARB_PRIO = 1'b1;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cluster_evt_arbiter_if.sv
// Bus bundle between event sources/sink and the event concentrator.
interface cluster_evt_arbiter_if
  import cluster_evt_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned EVNT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
);
  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic                         mode_i;
  logic                         drop_en_i;
  logic [N_CH-1:0]              evt_valid_i;
  logic [N_CH*EVNT_WIDTH-1:0]   evt_data_i;
  logic [N_CH-1:0]              evt_ready_o;
  logic                         evt_valid_o;
  logic [EVNT_WIDTH-1:0]        evt_data_o;
  logic [CH_W-1:0]              evt_ch_o;
  logic                         evt_ready_i;
  logic [N_CH-1:0]              overflow_o;
  logic [N_CH-1:0]              overflow_clr_i;
  logic [N_CH*CNT_WIDTH-1:0]    drop_cnt_o;
  logic                         empty_o;

  modport master (
    output mode_i, drop_en_i, evt_valid_i, evt_data_i, evt_ready_i, overflow_clr_i,
    input  evt_ready_o, evt_valid_o, evt_data_o, evt_ch_o, overflow_o, drop_cnt_o, empty_o
  );

  modport slave (
    input  mode_i, drop_en_i, evt_valid_i, evt_data_i, evt_ready_i, overflow_clr_i,
    output evt_ready_o, evt_valid_o, evt_data_o, evt_ch_o, overflow_o, drop_cnt_o, empty_o
  );

endinterface

// File: rtl/cluster_evt_fifo.sv
// Single-channel synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module cluster_evt_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned DEPTH = 2 ** LOG_DEPTH;

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr_r;
  logic [LOG_DEPTH:0] rd_ptr_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[LOG_DEPTH] != rd_ptr_r[LOG_DEPTH]) &&
                     (wr_ptr_r[LOG_DEPTH-1:0] == rd_ptr_r[LOG_DEPTH-1:0]);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = mem_r[rd_ptr_r[LOG_DEPTH-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (LOG_DEPTH+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (LOG_DEPTH+1)'(1);
      end
    end
  end

  // Storage write; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[LOG_DEPTH-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/cluster_evt_arbiter.sv
// Per-channel event FIFOs arbitrated (round robin or fixed priority) into one registered output slot.
module cluster_evt_arbiter
  import cluster_evt_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned EVNT_WIDTH = 8,
  parameter int unsigned LOG_DEPTH  = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cluster_evt_arbiter_if.slave bus
);
  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic [N_CH-1:0]            full_s;
  logic [N_CH-1:0]            empty_s;
  logic [N_CH-1:0]            push_s;
  logic [N_CH-1:0]            pop_s;
  logic [N_CH-1:0]            drop_s;
  logic [EVNT_WIDTH-1:0]      fifo_rd_s [N_CH];
  logic [CH_W-1:0]            base_s;
  logic [CH_W-1:0]            win_s;
  logic [CH_W-1:0]            rr_next_s;
  logic                       win_found_s;
  logic                       load_s;
  logic [N_CH*CNT_WIDTH-1:0]  drop_cnt_flat_s;

  logic                       slot_valid_r;
  logic [EVNT_WIDTH-1:0]      slot_data_r;
  logic [CH_W-1:0]            slot_ch_r;
  logic [CH_W-1:0]            rr_ptr_r;
  logic [N_CH-1:0]            overflow_r;
  logic [CNT_WIDTH-1:0]       drop_cnt_r [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_fifo
    cluster_evt_fifo #(
      .WIDTH     (EVNT_WIDTH),
      .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .push    (push_s[g]),
      .pop     (pop_s[g]),
      .wr_data (bus.evt_data_i[g*EVNT_WIDTH +: EVNT_WIDTH]),
      .rd_data (fifo_rd_s[g]),
      .full    (full_s[g]),
      .empty   (empty_s[g])
    );
  end

  // A full channel never accepts, even if it pops in the same cycle
  always_comb begin
    push_s = bus.evt_valid_i & ~full_s;
    if (bus.drop_en_i) begin
      drop_s = bus.evt_valid_i & full_s;
    end else begin
      drop_s = '0;
    end
  end

  assign bus.evt_ready_o = bus.drop_en_i ? {N_CH{1'b1}} : ~full_s;
  assign load_s          = ~slot_valid_r | bus.evt_ready_i;
  assign base_s          = (bus.mode_i == EVT_ARB_PRIO) ? '0 : rr_ptr_r;

  // Search non-empty FIFOs starting at base_s, wrapping modulo N_CH
  always_comb begin : arb_search
    logic [CH_W:0] idx_v;
    win_s       = '0;
    win_found_s = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx_v = {1'b0, base_s} + (CH_W+1)'(k);
      if (idx_v >= (CH_W+1)'(N_CH)) begin
        idx_v = idx_v - (CH_W+1)'(N_CH);
      end else begin
        idx_v = idx_v;
      end
      if (!win_found_s && !empty_s[idx_v[CH_W-1:0]]) begin
        win_found_s = 1'b1;
        win_s       = idx_v[CH_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign pop_s     = (load_s && win_found_s) ? (N_CH'(1) << win_s) : '0;
  assign rr_next_s = (win_s == CH_W'(N_CH-1)) ? '0 : win_s + CH_W'(1);

  // Output slot and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_r <= 1'b0;
      slot_data_r  <= '0;
      slot_ch_r    <= '0;
      rr_ptr_r     <= '0;
    end else if (load_s) begin
      slot_valid_r <= win_found_s;
      if (win_found_s) begin
        slot_data_r <= fifo_rd_s[win_s];
        slot_ch_r   <= win_s;
        if (bus.mode_i == EVT_ARB_RR) begin
          rr_ptr_r <= rr_next_s;
        end
      end
    end
  end

  // Sticky overflow (set beats clear) and saturating drop counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_r <= '0;
      for (int i = 0; i < N_CH; i++) begin
        drop_cnt_r[i] <= '0;
      end
    end else begin
      overflow_r <= (overflow_r & ~bus.overflow_clr_i) | drop_s;
      for (int i = 0; i < N_CH; i++) begin
        if (drop_s[i] && (drop_cnt_r[i] != {CNT_WIDTH{1'b1}})) begin
          drop_cnt_r[i] <= drop_cnt_r[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Flatten counters onto the bus
  always_comb begin
    drop_cnt_flat_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_cnt_flat_s[i*CNT_WIDTH +: CNT_WIDTH] = drop_cnt_r[i];
    end
  end

  assign bus.evt_valid_o = slot_valid_r;
  assign bus.evt_data_o  = slot_data_r;
  assign bus.evt_ch_o    = slot_ch_r;
  assign bus.overflow_o  = overflow_r;
  assign bus.drop_cnt_o  = drop_cnt_flat_s;
  assign bus.empty_o     = (&empty_s) & ~slot_valid_r;

endmodule

// File: tb/tb_cluster_evt_arbiter.sv
// Bench for cluster_evt_arbiter: directed vector table, corner sequences and a queue-based random reference.
module tb_cluster_evt_arbiter;
  import cluster_evt_pkg::*;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  cluster_evt_arbiter_if #(.N_CH(NCH), .EVNT_WIDTH(8), .CNT_WIDTH(8)) bus ();

  cluster_evt_arbiter #(
    .N_CH(NCH), .EVNT_WIDTH(8), .LOG_DEPTH(2), .CNT_WIDTH(8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: plain queues per channel plus the single output slot
  logic [7:0] mq [NCH][$];
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_rr;
  bit         m_ovf [NCH];
  int         m_cnt [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_rr    = 0;
  endtask

  task automatic model_update();
    bit full_pre [NCH];
    int w;
    int base;
    for (int i = 0; i < NCH; i++) full_pre[i] = (mq[i].size() == DEPTH);
    if (!m_valid || bus.evt_ready_i) begin
      w    = -1;
      base = bus.mode_i ? 0 : m_rr;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (base + k) % NCH;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = mq[w].pop_front();
        m_ch    = w;
        if (!bus.mode_i) m_rr = (w + 1) % NCH;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      bit dropped;
      dropped = 1'b0;
      if (bus.evt_valid_i[i]) begin
        if (!full_pre[i]) mq[i].push_back(bus.evt_data_i[i*8 +: 8]);
        else if (bus.drop_en_i) dropped = 1'b1;
      end
      if (dropped) begin
        m_ovf[i] = 1'b1;
        if (m_cnt[i] < 255) m_cnt[i]++;
      end else if (bus.overflow_clr_i[i]) begin
        m_ovf[i] = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_ovf;
    logic [31:0] exp_cnt;
    bit          all_empty;
    all_empty = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      exp_rdy[i] = bus.drop_en_i ? 1'b1 : (mq[i].size() != DEPTH);
      exp_ovf[i] = m_ovf[i];
      exp_cnt[i*8 +: 8] = 8'(m_cnt[i]);
      if (mq[i].size() != 0) all_empty = 1'b0;
    end
    check("ref_ready", 32'(bus.evt_ready_o), 32'(exp_rdy));
    check("ref_valid", 32'(bus.evt_valid_o), 32'(m_valid));
    if (m_valid) begin
      check("ref_data", 32'(bus.evt_data_o), 32'(m_data));
      check("ref_ch", 32'(bus.evt_ch_o), 32'(m_ch));
    end
    check("ref_overflow", 32'(bus.overflow_o), 32'(exp_ovf));
    check("ref_drop_cnt", bus.drop_cnt_o, exp_cnt);
    check("ref_empty", 32'(bus.empty_o), 32'(all_empty && !m_valid));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.evt_valid_i    = '0;
    bus.evt_data_i     = '0;
    bus.overflow_clr_i = '0;
    bus.evt_ready_i    = 1'b1;
    bus.mode_i         = EVT_ARB_RR;
    bus.drop_en_i      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic [31:0] data;
    bit          ready;
    bit          exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_ch;
    bit          exp_empty;
  } vec_t;

  vec_t vecs [11];

  initial begin
    evt_t        d1;
    evt_t        d3;
    int          acc_n;
    logic [3:0]  acc;
    bit          seen3;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    vecs[0]  = '{1'b1, 4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[1]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'hA5, 2'd2, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 4'b1111, 32'h1312_1110, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h10, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h11, 2'd1, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h12, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h13, 2'd3, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};

    // Reset values
    do_reset();
    #1;
    check("rst_valid", 32'(bus.evt_valid_o), 32'd0);
    check("rst_data", 32'(bus.evt_data_o), 32'd0);
    check("rst_ch", 32'(bus.evt_ch_o), 32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_drop_cnt", bus.drop_cnt_o, 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_ready", 32'(bus.evt_ready_o), 32'hF);
    @(negedge clk);

    // Single push latency and round-robin burst order
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst) do_reset();
      bus.evt_valid_i = vecs[v].valid;
      bus.evt_data_i  = vecs[v].data;
      bus.evt_ready_i = vecs[v].ready;
      #1;
      check($sformatf("vec%0d_valid", v), 32'(bus.evt_valid_o), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_empty", v), 32'(bus.empty_o), 32'(vecs[v].exp_empty));
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_data", v), 32'(bus.evt_data_o), 32'(vecs[v].exp_data));
        check($sformatf("vec%0d_ch", v), 32'(bus.evt_ch_o), 32'(vecs[v].exp_ch));
      end
      step();
    end

    // Fixed priority: ch1 starves ch3 while it keeps sending
    do_reset();
    bus.mode_i = EVT_ARB_PRIO;
    d1 = 8'h10;
    d3 = 8'h30;
    for (int c = 0; c < 12; c++) begin
      bus.evt_valid_i = 4'b1010;
      bus.evt_data_i  = {d3, 8'h00, d1, 8'h00};
      #1;
      acc = bus.evt_valid_i & bus.evt_ready_o;
      if (c >= 2) check("prio_valid", 32'(bus.evt_valid_o), 32'd1);
      if (c >= 2) check("prio_ch1_only", 32'(bus.evt_ch_o), 32'd1);
      step();
      if (acc[1]) d1 = d1 + 8'd1;
      if (acc[3]) d3 = d3 + 8'd1;
    end
    seen3 = 1'b0;
    for (int c = 0; c < 10 && !seen3; c++) begin
      bus.evt_valid_i = 4'b1000;
      bus.evt_data_i  = {d3, 24'h0};
      #1;
      acc = bus.evt_valid_i & bus.evt_ready_o;
      if (bus.evt_valid_o && bus.evt_ch_o == 2'd3) begin
        seen3 = 1'b1;
        check("prio_first_ch3", 32'(bus.evt_data_o), 32'h30);
      end
      step();
      if (acc[3]) d3 = d3 + 8'd1;
    end
    check("prio_ch3_appeared", 32'(seen3), 32'd1);

    // Backpressure: 4 in FIFO + 1 in slot, then the source holds
    do_reset();
    bus.evt_ready_i = 1'b0;
    d1 = 8'h40;
    acc_n = 0;
    for (int c = 0; c < 8; c++) begin
      bus.evt_valid_i = 4'b0001;
      bus.evt_data_i  = {24'h0, d1};
      #1;
      acc = bus.evt_valid_i & bus.evt_ready_o;
      if (c >= 2) check("bp_hold", {23'h0, bus.evt_valid_o, bus.evt_data_o}, {23'h0, 1'b1, 8'h40});
      step();
      if (acc[0]) begin
        d1 = d1 + 8'd1;
        acc_n++;
      end
    end
    check("bp_accepted", 32'(acc_n), 32'd5);
    check("bp_ready0_low", 32'(bus.evt_ready_o[0]), 32'd0);
    check("bp_held_word", 32'(d1), 32'h45);
    bus.evt_valid_i = '0;
    bus.evt_ready_i = 1'b1;
    repeat (8) step();

    // Drop mode overflow and counter
    do_reset();
    bus.drop_en_i   = 1'b1;
    bus.evt_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.evt_valid_i = 4'b0010;
      bus.evt_data_i  = {16'h0, 8'(8'h50 + c), 8'h00};
      step();
    end
    bus.evt_valid_i = '0;
    #1;
    check("drop_ovf_set", 32'(bus.overflow_o[1]), 32'd1);
    check("drop_cnt3", 32'(bus.drop_cnt_o[15:8]), 32'd3);
    bus.overflow_clr_i = 4'b0010;
    step();
    bus.overflow_clr_i = '0;
    #1;
    check("drop_ovf_clr", 32'(bus.overflow_o[1]), 32'd0);
    check("drop_cnt_kept", 32'(bus.drop_cnt_o[15:8]), 32'd3);
    bus.evt_valid_i    = 4'b0010;
    bus.overflow_clr_i = 4'b0010;
    step();
    bus.evt_valid_i    = '0;
    bus.overflow_clr_i = '0;
    #1;
    check("drop_set_wins", 32'(bus.overflow_o[1]), 32'd1);
    check("drop_cnt4", 32'(bus.drop_cnt_o[15:8]), 32'd4);
    step();

    // Asynchronous reset with events queued
    do_reset();
    bus.evt_ready_i = 1'b0;
    bus.evt_valid_i = 4'b0111;
    bus.evt_data_i  = 32'h0062_6160;
    step();
    bus.evt_valid_i = '0;
    step();
    #1;
    check("arst_pre_valid", 32'(bus.evt_valid_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid_drop", 32'(bus.evt_valid_o), 32'd0);
    check("arst_empty", 32'(bus.empty_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.evt_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("arst_no_stale", 32'(bus.evt_valid_o), 32'd0);
      step();
    end

    // Randomized traffic against the reference
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) bus.drop_en_i = 1'($urandom_range(0, 1));
      bus.mode_i         = ($urandom_range(0, 7) == 0) ? ~bus.mode_i : bus.mode_i;
      bus.evt_valid_i    = 4'($urandom);
      bus.evt_data_i     = $urandom;
      bus.evt_ready_i    = ($urandom_range(0, 3) != 0);
      bus.overflow_clr_i = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      step();
    end
    idle_inputs();
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cluster_evt_arbiter.md
Name: cluster_evt_arbiter

Overview:
Multi-channel event concentrator in the SoC domain. It collects event words from N_CH independent SoC sources (peripheral, FC and DMA event generators) and buffers each source in its own FIFO. It arbitrates the buffered events into a single valid/ready stream that feeds the SoC-to-cluster event-bus CDC writer. This generalises the former single fixed event path with configurable channel count, depth and width, selectable arbitration, drop-on-full mode and overflow reporting.

Parameters:
N_CH, 4, number of input event channels (2..16)
EVNT_WIDTH, 8, event word width in bits
LOG_DEPTH, 2, log2 of per-channel FIFO depth (DEPTH = 2**LOG_DEPTH, 1..4)
CNT_WIDTH, 8, width of per-channel saturating drop counters

Ports:
clk_i  in  1  SoC clock
rst_ni  in  1  asynchronous active-low reset
mode_i  in  1  0 = round robin, 1 = fixed priority (lowest index wins)
drop_en_i  in  1  1 = never backpressure; drop events that arrive while the channel is full
evt_valid_i  in  N_CH  per-channel event valid
evt_data_i  in  N_CH*EVNT_WIDTH  per-channel event word
evt_ready_o  out  N_CH  per-channel ready
evt_valid_o  out  1  output event valid
evt_data_o  out  EVNT_WIDTH  output event word
evt_ch_o  out  $clog2(N_CH)  source channel of the output event
evt_ready_i  in  1  downstream ready
overflow_o  out  N_CH  sticky per-channel overflow flag
overflow_clr_i  in  N_CH  per-channel overflow clear (one-cycle pulse)
drop_cnt_o  out  N_CH*CNT_WIDTH  per-channel saturating drop count
empty_o  out  1  all FIFOs and the output register are empty

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all FIFOs empty; output register invalid; RR pointer 0; evt_valid_o=0, evt_data_o=0, evt_ch_o=0, overflow_o=0, drop_cnt_o=0, empty_o=1. evt_ready_o=~full, so it reads all-ones after reset.
- Push (backpressure mode, drop_en_i=0): evt_ready_o[i]=~full[i]. A push occurs when valid&ready. There is no pass-through when full, even if the same channel pops in the same cycle.
- Push (drop mode, drop_en_i=1): evt_ready_o[i]=1. Valid while full[i] -> word discarded, overflow_o[i] set next cycle, drop_cnt[i]+1 saturating at 2**CNT_WIDTH-1.
- FIFO: per-channel circular buffer. Read and write pointers are LOG_DEPTH+1 bits wide; the MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- Output stage: a single registered slot (valid, data, ch). The slot loads when it is empty or when evt_valid_o&evt_ready_i. The load pops the winning FIFO in the same edge.
- Latency: an event pushed at edge t is visible on evt_valid_o after edge t+1 (2 cycles, minimum). Sustained throughput is 1 event/cycle.
- Output hold: while evt_valid_o=1 and evt_ready_i=0, data and ch stay stable and no pop occurs.
- Round robin: search starts at the RR pointer among non-empty FIFOs. On load, the pointer becomes (winner+1) mod N_CH. The pointer is frozen when there is no load.
- Fixed priority: lowest non-empty index wins; the RR pointer is not updated.
- mode_i change takes effect on the next arbitration and never affects the already-loaded slot.
- Overflow: set has priority over overflow_clr_i in the same cycle. overflow_clr_i does not clear drop_cnt; drop_cnt clears only on reset.
- Simultaneous push and pop on a non-full channel: both occur and occupancy is unchanged. Push and pop on an empty channel: the word is stored and is not popped that cycle (no bypass).
- empty_o is combinational: no FIFO holds data and the output slot is invalid.
- Reset mid-operation: all state drops immediately with no flush. Events in flight are lost.

Decomposition:
- Package cluster_evt_pkg: evt_t (logic [EVNT_WIDTH-1:0]), mode encoding constants (EVT_ARB_RR=1'b0, EVT_ARB_PRIO=1'b1), and the channel index width function.
- Sub-module cluster_evt_fifo: single-channel sync FIFO with push/pop/full/empty, instantiated N_CH times.
- The arbiter and output slot stay in the top module.

Test Plan:
- Reset, then a single push on ch2 with data 0xA5 and evt_ready_i=1 -> evt_valid_o=1 with data 0xA5, ch=2 exactly 2 cycles later; empty_o=1 afterwards.
- RR mode, all 4 channels each push one word (0x10..0x13) in the same cycle, ready=1 -> output order ch0,ch1,ch2,ch3 on consecutive cycles.
- Prio mode, ch3 and ch1 continuously valid, ready=1 -> only ch1 words appear until ch1 stops, then ch3.
- Backpressure, DEPTH=4, ready=0, ch0 pushes 6 words -> 4 accepted into the FIFO plus 1 in the output slot; evt_ready_o[0]=0 from then on; the 6th word is held by the source. Output is stable throughout.
- Drop mode, ready=0, ch1 pushes 8 words -> overflow_o[1]=1 and drop_cnt[1]=3. Pulse overflow_clr_i[1] -> flag 0, count still 3. A simultaneous drop and clear leaves the flag at 1.
- Assert rst_ni low asynchronously mid-stream with 3 events queued -> evt_valid_o drops to 0 without a clock edge. After release, empty_o=1 and no stale event appears.
